// File: rtl/mem_port_arbiter.sv
// Shared RAM port arbiter: loader > round-robin fetch/data, IDLE->ACCESS->DONE sequence, ack in DONE.
// Optional loader requester enabled by defining MEM_ARB_LOADER_EN.
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              f_req,
  input  logic              d_req,
  input  logic              l_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic              d_we,
  input  logic              l_we,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              f_ack,
  output logic              d_ack,
  output logic              l_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state;
  logic              last_fd;   // 1: data was the last fetch/data winner
  logic [1:0]        win;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    win = 2'b00;
    if (f_req && d_req) win = last_fd ? 2'b01 : 2'b10;
    else if (f_req)     win = 2'b01;
    else if (d_req)     win = 2'b10;
`ifdef MEM_ARB_LOADER_EN
    if (l_req)          win = 2'b11;
`endif
  end

`ifndef MEM_ARB_LOADER_EN
  logic unused_l_req;
  assign unused_l_req = l_req;
`endif

  // Fetch never writes; its write data is forced to zero.
  always_comb begin
    sel_addr  = f_addr;
    sel_we    = 1'b0;
    sel_wdata = '0;
    case (win)
      2'b10: begin
        sel_addr  = d_addr;
        sel_we    = d_we;
        sel_wdata = d_wdata;
      end
      2'b11: begin
        sel_addr  = l_addr;
        sel_we    = l_we;
        sel_wdata = l_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      owner     <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      last_fd   <= 1'b1;
      f_ack     <= 1'b0;
      d_ack     <= 1'b0;
      l_ack     <= 1'b0;
    end else begin
      f_ack  <= 1'b0;
      d_ack  <= 1'b0;
      l_ack  <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (win != 2'b00) begin
            owner     <= win;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_we    <= sel_we;
            busy      <= 1'b1;
            state     <= ACCESS;
            if (win != 2'b11) last_fd <= (win == 2'b10);
          end else begin
            owner <= 2'b00;
          end
        end
        ACCESS: begin
          // Captures the pre-write value when this access is a write.
          rdata <= mem_rdata;
          f_ack <= (owner == 2'b01);
          d_ack <= (owner == 2'b10);
          l_ack <= (owner == 2'b11);
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          owner <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model plus directed scenarios.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        f_req, d_req, l_req;
  logic [7:0]  f_addr, d_addr, l_addr;
  logic        d_we, l_we;
  logic [15:0] d_wdata, l_wdata;
  logic        f_ack, d_ack, l_ack;
  logic [15:0] rdata;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;
  logic [1:0]  owner;

  int errors = 0;
  int checks = 0;
  logic init_ram;
  logic chk_en;
  logic l_seen;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .f_req(f_req), .d_req(d_req), .l_req(l_req),
    .f_addr(f_addr), .d_addr(d_addr), .l_addr(l_addr),
    .d_we(d_we), .l_we(l_we),
    .d_wdata(d_wdata), .l_wdata(l_wdata),
    .f_ack(f_ack), .d_ack(d_ack), .l_ack(l_ack),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  // Environment RAM: combinational read, write on the clock edge.
  logic [15:0] ram [256];
  assign mem_rdata = ram[mem_addr];
  always @(posedge CLK) begin
    if (init_ram) begin
      for (int i = 0; i < 256; i++) ram[i] <= (i == 5) ? 16'h1234 : (16'hA500 | 16'(i));
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: one access per three cycles (sample, RAM access, acknowledge).
  logic [15:0] model_ram [256];
  int          m_phase;
  logic [1:0]  m_owner;
  logic [7:0]  m_addr;
  logic        m_we;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        m_last_data;

  function automatic logic [1:0] pick(input logic l, input logic f, input logic d, input logic last_data);
`ifdef MEM_ARB_LOADER_EN
    if (l) return 2'd3;
`endif
    if (f && d) return last_data ? 2'd1 : 2'd2;
    if (f) return 2'd1;
    if (d) return 2'd2;
    return 2'd0;
  endfunction

  logic [1:0] m_pick;
  assign m_pick = pick(l_req, f_req, d_req, m_last_data);

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_phase <= 0; m_owner <= 0; m_addr <= 0; m_we <= 0;
      m_wdata <= 0; m_rdata <= 0; m_last_data <= 1'b1;
    end else if (m_phase == 0) begin
      m_owner <= m_pick;
      if (m_pick != 0) begin
        m_phase <= 1;
        m_addr  <= (m_pick == 1) ? f_addr : (m_pick == 2) ? d_addr : l_addr;
        m_we    <= (m_pick == 2) ? d_we : (m_pick == 3) ? l_we : 1'b0;
        m_wdata <= (m_pick == 2) ? d_wdata : (m_pick == 3) ? l_wdata : 16'h0;
        if (m_pick == 1) m_last_data <= 1'b0;
        if (m_pick == 2) m_last_data <= 1'b1;
      end
    end else if (m_phase == 1) begin
      m_rdata <= model_ram[m_addr];
      m_phase <= 2;
    end else begin
      m_phase <= 0;
      m_owner <= 0;
    end
  end

  always @(posedge CLK) begin
    if (init_ram) begin
      for (int i = 0; i < 256; i++) model_ram[i] <= (i == 5) ? 16'h1234 : (16'hA500 | 16'(i));
    end else if (RST && m_phase == 1 && m_we) begin
      model_ram[m_addr] <= m_wdata;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("cyc_f_ack", f_ack, (m_phase == 2 && m_owner == 1));
      check("cyc_d_ack", d_ack, (m_phase == 2 && m_owner == 2));
      check("cyc_l_ack", l_ack, (m_phase == 2 && m_owner == 3));
      check("cyc_busy", busy, (m_phase != 0));
      check("cyc_owner", owner, m_owner);
      check("cyc_mem_we", mem_we, (m_phase == 1 && m_we));
      check("cyc_mem_addr", mem_addr, m_addr);
      check("cyc_mem_wdata", mem_wdata, m_wdata);
      check("cyc_rdata", rdata, m_rdata);
      if (l_ack) l_seen = 1'b1;
    end
  end

  task automatic wait_ack(input int max, output int n, output logic [1:0] who);
    n = 0;
    who = 0;
    while (who == 0 && n < max) begin
      @(negedge CLK);
      n++;
      if (l_ack) who = 3;
      else if (d_ack) who = 2;
      else if (f_ack) who = 1;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  int         n;
  logic [1:0] who;
  int         seq_who [$];
  int         seq_cyc [$];

  initial begin
    RST = 1'b0; init_ram = 1'b1; chk_en = 1'b0; l_seen = 1'b0;
    f_req = 0; d_req = 0; l_req = 0;
    f_addr = 0; d_addr = 0; l_addr = 0;
    d_we = 0; l_we = 0; d_wdata = 0; l_wdata = 0;
    repeat (2) @(negedge CLK);
    init_ram = 1'b0;
    chk_en = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    RST = 1'b1;

    // Fetch read of address 5.
    f_req = 1; f_addr = 8'h05;
    @(negedge CLK);
    check("t1_busy", busy, 1);
    check("t1_owner", owner, 2'b01);
    check("t1_mem_addr", mem_addr, 8'h05);
    wait_ack(6, n, who);
    check("t1_latency", n, 1);
    check("t1_who", who, 1);
    check("t1_rdata", rdata, 16'h1234);
    f_req = 0;
    repeat (2) @(negedge CLK);
    check("idle_busy", busy, 0);
    check("idle_owner", owner, 0);
    check("idle_mem_we", mem_we, 0);
    check("idle_rdata_hold", rdata, 16'h1234);

    // Data write then back-to-back read of 0x10.
    d_req = 1; d_we = 1; d_addr = 8'h10; d_wdata = 16'hBEEF;
    @(negedge CLK);
    check("t2_we_access", mem_we, 1);
    wait_ack(6, n, who);
    check("t2_wr_who", who, 2);
    check("t2_wr_we_done", mem_we, 0);
    d_we = 0;
    @(negedge CLK);
    check("t2_we_idle", mem_we, 0);
    wait_ack(6, n, who);
    check("t2_rd_latency", n, 2);
    check("t2_rd_who", who, 2);
    check("t2_rd_data", rdata, 16'hBEEF);
    d_req = 0;

    // Fetch and data tied for 12 cycles after reset.
    do_reset();
    f_addr = 8'h05; d_addr = 8'h10; d_we = 0;
    f_req = 1; d_req = 1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (f_ack) begin seq_who.push_back(1); seq_cyc.push_back(k); end
      if (d_ack) begin seq_who.push_back(2); seq_cyc.push_back(k); end
    end
    f_req = 0; d_req = 0;
    check("t3_count", seq_who.size(), 4);
    if (seq_who.size() == 4) begin
      check("t3_g0", seq_who[0], 1);
      check("t3_g1", seq_who[1], 2);
      check("t3_g2", seq_who[2], 1);
      check("t3_g3", seq_who[3], 2);
      check("t3_c0", seq_cyc[0], 2);
      check("t3_c3", seq_cyc[3], 11);
    end

    // All three requesting.
    do_reset();
    l_req = 1; l_addr = 8'h05; l_we = 0;
    f_req = 1; d_req = 1;
    wait_ack(6, n, who);
`ifdef MEM_ARB_LOADER_EN
    check("t4_first_loader", who, 3);
    l_req = 0;
    wait_ack(8, n, who);
    check("t4_second_fetch", who, 1);
    check("t4_second_lat", n, 3);
`else
    check("t4_first_fetch", who, 1);
    wait_ack(8, n, who);
    check("t4_second_data", who, 2);
    check("t4_second_lat", n, 3);
`endif
    l_req = 0; f_req = 0; d_req = 0;
    @(negedge CLK);

    // Reset in the middle of a write access.
    d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 16'h5555;
    @(negedge CLK);
    check("t5_pre_we", mem_we, 1);
    #2 RST = 1'b0;
    #1;
    check("t5_mem_we", mem_we, 0);
    check("t5_busy", busy, 0);
    check("t5_owner", owner, 0);
    check("t5_rdata", rdata, 0);
    check("t5_d_ack", d_ack, 0);
    check("t5_mem_addr", mem_addr, 0);
    d_req = 0; d_we = 0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    d_addr = 8'h10; f_addr = 8'h05;
    f_req = 1; d_req = 1;
    wait_ack(6, n, who);
    check("t5_tie_fetch", who, 1);
    check("t5_tie_lat", n, 2);
    check("t5_tie_rdata", rdata, 16'h1234);
    f_req = 0; d_req = 0;
    repeat (3) @(negedge CLK);

`ifndef MEM_ARB_LOADER_EN
    check("l_ack_never", l_seen, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and access sequencer for the single shared port of the distributed instruction/data RAM in the multi-cycle CPU. It grants the RAM's read port i and write port to one of three requesters: instruction fetch, data load/store, and the manual program loader. Each granted access runs through a fixed three-state sequence and returns registered read data with a one-cycle acknowledge. The block sits between the fetch/datapath logic and the RAM, in place of direct wiring of PC and manual-write signals.

## Interface
- ADDR_W, 8, RAM address width (drives read_i / write_addr)
- DATA_W, 16, RAM data width
- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  asynchronous, active-low reset
- f_req / d_req / l_req  in  1  access request from fetch / data / loader; held until matching ack
- f_addr / d_addr / l_addr  in  ADDR_W  access address per requester
- d_we / l_we  in  1  1 = write, 0 = read (fetch is read-only)
- d_wdata / l_wdata  in  DATA_W  write data per requester
- f_ack / d_ack / l_ack  out  1  one-cycle completion pulse to the owning requester
- rdata  out  DATA_W  registered RAM read data, valid while any ack is high, held afterwards
- mem_addr  out  ADDR_W  drives RAM read_i and write_addr
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write_data
- mem_rdata  in  DATA_W  RAM out_i (combinational read)
- busy  out  1  high in ACCESS and DONE
- owner  out  2  00 none, 01 fetch, 10 data, 11 loader; registered winner

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: sample requests. If any is high, latch winner into owner, and latch its addr, we, wdata into internal registers; go ACCESS. Else stay IDLE, owner = 00.
- Priority: loader absolute highest. Fetch vs data: round-robin on last_fd bit (last fetch/data winner); the one not served last wins a tie. Loader wins do not change last_fd.
- ACCESS: mem_addr = latched addr; mem_we = latched we; mem_wdata = latched wdata. RAM write commits on the edge ending ACCESS. mem_rdata captured into rdata on the same edge (read-before-write value on a write cycle; rdata on write is don't-care for the requester). Go DONE.
- DONE: assert the ack for owner only; mem_we = 0; go IDLE unconditionally. Requests are not sampled in DONE.
- Requester rule: deassert req on the edge ending the ack cycle unless issuing a new access; a still-high req in the following IDLE is a new access.
- Outside ACCESS: mem_we = 0, mem_addr = latched addr (stable, no glitch to RAM).
- Fetch writes impossible: fetch latches we = 0.
- Requests changing while not owner are allowed; only the IDLE-cycle values matter.

## Timing
- Latency: req high in IDLE at edge N -> ACCESS cycle N+1 -> ack high in cycle N+2. Throughput: one access per 3 cycles.
- Reset (RST = 0, any time, asynchronous): state = IDLE, all acks 0, mem_we 0, mem_addr 0, mem_wdata 0, rdata 0, owner 00, busy 0, last_fd = data (fetch wins first tie).
- Reset during ACCESS: mem_we drops immediately; the write is not guaranteed to commit; no ack is issued after reset release.
- Reset release: first request sampled on the first rising edge with RST = 1.
- Simultaneous f_req/d_req/l_req: loader, then (on next IDLE) round-robin between fetch and data.
- Continuous loader requests starve fetch and data by design.

## Configuration
- MEM_ARB_LOADER_EN defined: loader port arbitrates with top priority as above.
- Not defined: l_req, l_addr, l_we, l_wdata ignored; l_ack tied 0; owner never 11; arbitration is pure fetch/data round-robin. Port list unchanged.

## Test plan
- Reset then f_req = 1, f_addr = 0x05, RAM[5] = 0x1234 -> ACCESS one cycle later, f_ack pulse two cycles after sample, rdata = 0x1234, owner = 01.
- d_req write, d_addr = 0x10, d_wdata = 0xBEEF; then d_req read 0x10 -> mem_we = 1 only in ACCESS, read returns 0xBEEF, d_ack twice.
- f_req and d_req held high together for 12 cycles after reset -> grants alternate F, D, F, D (four acks, 3 cycles apart).
- l_req, d_req, f_req all high (MEM_ARB_LOADER_EN defined) -> loader served first; with macro undefined -> l_ack never asserted, fetch first.
- Assert RST low mid-ACCESS of a write to 0x20 -> acks 0, busy 0, owner 00, rdata 0 immediately; no ack after release; next f/d tie goes to fetch.
- Request dropped in DONE, none pending -> returns to IDLE, busy 0, mem_we 0, rdata holds last value.
